modn_updn_counter: RTL and testbench
====================================

MODN_UPDN_COUNTER -- requirements
Module: modn_updn_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and modulus width in bits; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: count enable.
REQ-005 The block SHALL have port up, input, 1 bit: direction select, 1 = up, 0 = down.
REQ-006 The block SHALL have ports load (input, 1 bit) and load_val (input, WIDTH bits): synchronous parallel load request and its value.
REQ-007 The block SHALL have ports mod_wr (input, 1 bit) and mod_val (input, WIDTH bits): modulus write request and requested modulus N.
REQ-008 The block SHALL have port count, output, WIDTH bits: registered counter value.
REQ-009 The block SHALL have port modulus, output, WIDTH bits: registered active modulus N.
REQ-010 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle wrap pulse.
REQ-012 The block SHALL have port mod_err, output, 1 bit: sticky error flag.

Function
REQ-013 Count range SHALL be 0..N-1, where N is the active modulus; legal N is 2..2^WIDTH-1.
REQ-014 Per-cycle priority SHALL be: reset > load > en-count > hold.
REQ-015 With en=1, up=1 and count!=N-1, count SHALL increment by 1; with count==N-1 it SHALL go to 0.
REQ-016 With en=1, up=0 and count!=0, count SHALL decrement by 1; with count==0 it SHALL go to N-1, using the post-promotion N (see REQ-021).
REQ-017 With en=0 and load=0, count SHALL hold.
REQ-018 The up input SHALL be sampled every cycle; a direction change takes effect on the same edge, with no extra latency.
REQ-019 tc SHALL equal en & ~load & ((up & count==N-1) | (~up & count==0)).
REQ-020 wrap SHALL be 1 for exactly the one cycle following any edge on which the tc condition caused a wrap transition; it SHALL be 0 otherwise, including after a load.
REQ-021 Modulus write handling SHALL be:
- mod_wr=1 with legal mod_val: mod_val is stored into a pending register, the pending flag is set, and the active N is unchanged.
- The pending N SHALL be promoted to active N on the edge where a wrap occurs, and the pending flag cleared.
- A later mod_wr before promotion overwrites the pending value.
REQ-022 If mod_wr and a wrap fall on the same edge, the wrap SHALL promote the previously pending value (if any), and the new mod_val SHALL become the pending value.
REQ-023 mod_wr with mod_val < 2 SHALL be ignored, with pending state unchanged, and SHALL set mod_err.
REQ-024 load=1 SHALL set count to load_val if load_val < N; otherwise count SHALL be set to N-1 and mod_err set. Load SHALL NOT promote a pending modulus.
REQ-025 mod_err SHALL remain set until reset.
REQ-026 count SHALL never leave 0..N-1 in any cycle after reset.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL set: count=0, modulus=2^WIDTH-1, pending flag cleared, wrap=0, mod_err=0.
REQ-028 Reset SHALL override load, mod_wr and en on the same edge.
REQ-029 Reset mid-count SHALL discard any pending modulus.
REQ-030 Before the first reset, output values SHALL be unspecified; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-031 Up wrap: WIDTH=8, mod_wr with mod_val=5, then en=1, up=1 for 12 cycles from reset -> promotion at the first wrap (254->0); thereafter count 0,1,2,3,4,0; tc high at count 4; wrap high the cycle after each 4->0 transition.
REQ-032 Down wrap: N=5 active, count=0, en=1, up=0 -> count sequence 4,3,2,1,0,4; tc high at count 0.
REQ-033 Mid-run direction flip: N=6, count=3, up toggled each cycle -> count 4,3,4,3; no wrap pulse.
REQ-034 Deferred modulus: N=10, count=2, up, mod_wr mod_val=4 -> modulus stays 10 until the 9->0 wrap, then counts 0..3; down wrap after promotion lands on 3.
REQ-035 Errors and priority: mod_wr mod_val=1 -> mod_err=1, N unchanged. load_val=12 with N=10 -> count=9. reset together with load=1 -> count=0, mod_err=0.

Source files
------------

// File: rtl/modn_updn_counter.sv
// ---------------------------------------------------------------------------
// modn_updn_counter
//   Modulo-N up/down counter with a deferred modulus update.
//   The count stays within 0..N-1. A new modulus is written into a pending
//   register and becomes active only on a wrap, so the count never lands
//   outside the new range.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   en        in   count enable
//   up        in   direction: 1 = up, 0 = down
//   load      in   parallel load request
//   load_val  in   value for load (clamped to N-1 if out of range)
//   mod_wr    in   modulus write request
//   mod_val   in   requested modulus N (values below 2 are rejected)
//   count     out  registered count value
//   modulus   out  registered active modulus N
//   tc        out  combinational terminal-count flag
//   wrap      out  registered pulse, high for the cycle after a wrap
//   mod_err   out  sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module modn_updn_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] modulus,
    output logic             tc,
    output logic             wrap,
    output logic             mod_err
);

    localparam logic [WIDTH-1:0] MOD_RST = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOD_MIN = WIDTH'(2);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             at_top;
    logic             at_bot;
    logic             tc_cond;

    assign at_top  = (count_q == (mod_q - ONE));
    assign at_bot  = (count_q == '0);
    assign tc_cond = en & ~load & (up ? at_top : at_bot);

    always_comb begin
        count_d    = count_q;
        mod_d      = mod_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        err_d      = err_q;
        wrap_d     = tc_cond;

        // Promotion happens first so that a down wrap lands on the new N-1.
        if (tc_cond && pend_q) begin
            mod_d  = pend_val_q;
            pend_d = 1'b0;
        end

        if (tc_cond) begin
            count_d = up ? '0 : (mod_d - ONE);
        end else if (load) begin
            if (load_val < mod_q) begin
                count_d = load_val;
            end else begin
                count_d = mod_q - ONE;
                err_d   = 1'b1;
            end
        end else if (en) begin
            count_d = up ? (count_q + ONE) : (count_q - ONE);
        end

        // A write on the wrap edge becomes the next pending value; the
        // previously pending one has already been promoted above.
        if (mod_wr) begin
            if (mod_val >= MOD_MIN) begin
                pend_val_d = mod_val;
                pend_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            mod_q      <= MOD_RST;
            pend_val_q <= MOD_RST;
            pend_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            mod_q      <= mod_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign count   = count_q;
    assign modulus = mod_q;
    assign tc      = tc_cond;
    assign wrap    = wrap_q;
    assign mod_err = err_q;

endmodule

// File: tb/tb_modn_updn_counter.sv
module tb_modn_updn_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, en, up, load, mod_wr;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] count, modulus;
    logic         tc, wrap, mod_err;

    int checks = 0;
    int errors = 0;

    modn_updn_counter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up),
        .load(load), .load_val(load_val),
        .mod_wr(mod_wr), .mod_val(mod_val),
        .count(count), .modulus(modulus),
        .tc(tc), .wrap(wrap), .mod_err(mod_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] m_cnt, m_mod, m_pv;
    logic         m_pf, m_wrap, m_err;
    bit           m_valid = 1'b0;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [W-1:0] md;
        logic         wr;
        logic         er;
    } exp_t;

    exp_t sb[$];

    function automatic logic model_tc(logic e, logic u, logic l);
        if (!e || l) return 1'b0;
        if (u) return (m_cnt == m_mod - 8'd1);
        return (m_cnt == 8'd0);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic u,
                              input logic l, input logic [W-1:0] lv,
                              input logic mw, input logic [W-1:0] mv);
        logic t;
        if (r) begin
            m_cnt = 8'd0; m_mod = 8'd255; m_pf = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
            m_valid = 1'b1;
            return;
        end
        t = model_tc(e, u, l);
        if (t && m_pf) begin
            m_mod = m_pv;
            m_pf  = 1'b0;
        end
        if (t)            m_cnt = u ? 8'd0 : m_mod - 8'd1;
        else if (l) begin
            if (lv < m_mod) m_cnt = lv;
            else begin m_cnt = m_mod - 8'd1; m_err = 1'b1; end
        end
        else if (e)       m_cnt = u ? m_cnt + 8'd1 : m_cnt - 8'd1;
        if (mw) begin
            if (mv >= 8'd2) begin m_pv = mv; m_pf = 1'b1; end
            else m_err = 1'b1;
        end
        m_wrap = t;
    endtask

    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [W-1:0] lv,
                       input logic mw, input logic [W-1:0] mv,
                       input string tag);
        exp_t x, o;
        logic t_exp;
        reset = r; en = e; up = u; load = l; load_val = lv; mod_wr = mw; mod_val = mv;
        #1;
        if (m_valid) begin
            t_exp = model_tc(e, u, l);
            checks++;
            assert (tc === t_exp) else begin
                errors++;
                $error("FAIL %s tc: observed %0b expected %0b", tag, tc, t_exp);
            end
        end
        model_step(r, e, u, l, lv, mw, mv);
        sb.push_back('{cnt: m_cnt, md: m_mod, wr: m_wrap, er: m_err});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        o = '{cnt: count, md: modulus, wr: wrap, er: mod_err};
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d mod=%0d wrap=%0b err=%0b expected cnt=%0d mod=%0d wrap=%0b err=%0b",
                   tag, o.cnt, o.md, o.wr, o.er, x.cnt, x.md, x.wr, x.er);
        end
    endtask

    // Checks a known constant sequence point independently of the model.
    task automatic expect_cnt(input logic [W-1:0] c, input logic [W-1:0] n, input string tag);
        checks++;
        assert (count === c && modulus === n) else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d mod=%0d expected cnt=%0d mod=%0d", tag, count, modulus, c, n);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; mod_wr = 1'b0; mod_val = '0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 0, 0, 0, 0, 0, 0, "reset2");
        expect_cnt(8'd0, 8'd255, "reset_const");

        // Up wrap with deferred modulus 5
        cyc(0, 0, 1, 0, 0, 1, 8'd5, "wr5");
        expect_cnt(8'd0, 8'd255, "wr5_deferred");
        cyc(0, 0, 1, 1, 8'd254, 0, 0, "load254");
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0, 0, "upwrap");
        // 254->0, then 0,1,2,3,4,0,...: 12 steps end at 1
        expect_cnt(8'd1, 8'd5, "upwrap_end");

        // Down wrap with N=5 from 0
        cyc(0, 0, 0, 1, 8'd0, 0, 0, "load0");
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 0, "dnwrap");
        expect_cnt(8'd4, 8'd5, "dnwrap_end");

        // Promote N=6 via up wrap, then direction flip around 3
        cyc(0, 0, 1, 0, 0, 1, 8'd6, "wr6");
        cyc(0, 1, 1, 0, 0, 0, 0, "wrap_to6");
        expect_cnt(8'd0, 8'd6, "n6_active");
        cyc(0, 0, 1, 1, 8'd3, 0, 0, "load3");
        for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2 == 0), 0, 0, 0, 0, "flip");
        expect_cnt(8'd3, 8'd6, "flip_end");

        // N=10 active, deferred write of 4, load does not promote
        cyc(0, 0, 1, 0, 0, 1, 8'd10, "wr10");
        cyc(0, 0, 1, 1, 8'd5, 0, 0, "load5");
        cyc(0, 1, 1, 0, 0, 0, 0, "wrap_to10");
        cyc(0, 0, 1, 1, 8'd2, 1, 8'd4, "load2_wr4");
        expect_cnt(8'd2, 8'd10, "n10_load_no_promote");
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0, 0, 0, "up_to_wrap");
        expect_cnt(8'd0, 8'd4, "promote4");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0, "up_n4");
        // mod_wr on the wrap edge: no pending, new value becomes pending
        cyc(0, 1, 1, 0, 0, 1, 8'd7, "wrap_and_wr7");
        expect_cnt(8'd0, 8'd4, "wr7_pending");
        cyc(0, 1, 0, 0, 0, 0, 0, "dn_wrap_to7");
        expect_cnt(8'd6, 8'd7, "dn_lands_n7m1");
        cyc(0, 1, 0, 0, 0, 0, 0, "dn");
        cyc(0, 0, 0, 0, 0, 0, 0, "hold");
        cyc(0, 0, 1, 0, 0, 0, 0, "hold2");

        // Errors and priority
        cyc(0, 0, 0, 0, 0, 1, 8'd1, "bad_mod");
        expect_cnt(8'd5, 8'd7, "bad_mod_n_same");
        cyc(0, 0, 0, 0, 0, 0, 0, "err_sticky");
        cyc(1, 1, 1, 1, 8'd3, 1, 8'd9, "reset_prio");
        cyc(0, 0, 1, 0, 0, 1, 8'd10, "wr10b");
        cyc(0, 0, 1, 1, 8'd254, 0, 0, "load254b");
        cyc(0, 1, 1, 0, 0, 0, 0, "wrap_to10b");
        cyc(0, 0, 1, 1, 8'd12, 0, 0, "load12");
        expect_cnt(8'd9, 8'd10, "load12_clamp");
        cyc(0, 1, 1, 0, 0, 0, 0, "wrap_after_clamp");
        // Pending discarded by reset
        cyc(0, 0, 1, 0, 0, 1, 8'd3, "wr3");
        cyc(1, 0, 1, 1, 8'd5, 0, 0, "reset_load");
        cyc(0, 0, 1, 1, 8'd254, 0, 0, "load254c");
        cyc(0, 1, 1, 0, 0, 0, 0, "wrap_no_pend");
        expect_cnt(8'd0, 8'd255, "pend_discarded");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
